fp16_addsub_ctrl: RTL and testbench



---
 rtl/fp16_pkg.sv | 30 +++
 rtl/fp16_addsub_ctrl_if.sv | 25 ++
 rtl/fp16_mant_addsub.sv | 28 ++
 rtl/fp16_addsub_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_fp16_addsub_ctrl.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - fp16 format widths, special encodings and sequencer states
package fp16_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    // working mantissa: {hidden, frac, G, R, S}
    localparam int MANT_W = FRAC_W + 4;

    localparam logic [EXP_W-1:0] EXP_MAX   = 5'd31;
    localparam logic [15:0]      QNAN      = 16'h7E00;
    localparam logic [15:0]      INF_P     = 16'h7C00;
    localparam logic [3:0]       ALIGN_CAP = 4'd14;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_ROUND = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/fp16_addsub_ctrl_if.sv
// rtl/fp16_addsub_ctrl_if.sv - operand/result handshake bundle of the fp16 add/sub sequencer
interface fp16_addsub_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic        out_ovf;
    logic        out_inv;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_res, out_ovf, out_inv
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_res, out_ovf, out_inv
    );

endinterface

// File: rtl/fp16_mant_addsub.sv
// rtl/fp16_mant_addsub.sv - sign-magnitude add/sub of aligned fp16 working mantissas
module fp16_mant_addsub
    import fp16_pkg::*;
(
    input  logic [MANT_W-1:0] a_i,
    input  logic [MANT_W-1:0] b_i,
    input  logic              sa_i,
    input  logic              sb_i,
    output logic [MANT_W-1:0] mag_o,
    output logic              carry_o,
    output logic              sign_o
);

    logic              sub;
    logic              neg;
    logic [MANT_W:0]   sum;

    always_comb begin
        sub = sa_i ^ sb_i;
        sum = {1'b0, a_i} + (sub ? ~{1'b0, b_i} : {1'b0, b_i}) + {{MANT_W{1'b0}}, sub};
        // on subtract the top bit is the sign of a-b, on add it is the carry
        neg     = sub & sum[MANT_W];
        mag_o   = neg ? (~sum[MANT_W-1:0] + {{(MANT_W-1){1'b0}}, 1'b1}) : sum[MANT_W-1:0];
        sign_o  = neg ? sb_i : sa_i;
        carry_o = ~sub & sum[MANT_W];
    end

endmodule

// File: rtl/fp16_addsub_ctrl.sv
// rtl/fp16_addsub_ctrl.sv - multi-cycle fp16 add/sub sequencer, FP16_ROUND_NEAREST_EN selects RNE rounding
module fp16_addsub_ctrl
    import fp16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    fp16_addsub_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic              first_q, first_d;
    logic [MANT_W-1:0] mx_q, mx_d, my_q, my_d;
    logic [EXP_W-1:0]  e_q, e_d;
    logic [3:0]        sh_q, sh_d;
    logic              carry_q, carry_d, sx_q, sx_d, sy_q, sy_d;
    logic              spec_inv_q, spec_inv_d, spec_inf_q, spec_inf_d;
    logic [15:0]       res_q, res_d;
    logic              ovf_q, ovf_d, inv_q, inv_d, valid_q, valid_d;

    fp16_t             a_f, b_f, x_f, y_f;
    logic              swap, x_nan, x_inf, y_inf;
    logic [EXP_W-1:0]  d;
    logic [MANT_W-1:0] mag;
    logic              add_carry, add_sign;
    logic [MANT_W-1:0] norm_m;
    logic [EXP_W-1:0]  norm_e;
`ifdef FP16_ROUND_NEAREST_EN
    logic              rnd_up;
    logic [FRAC_W+1:0] rnd_sum;
`endif

    fp16_mant_addsub u_mant (
        .a_i     (mx_q),
        .b_i     (my_q),
        .sa_i    (sx_q),
        .sb_i    (sy_q),
        .mag_o   (mag),
        .carry_o (add_carry),
        .sign_o  (add_sign)
    );

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = valid_q;
    assign bus.out_res   = res_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_inv   = inv_q;

    // operand decode; X is the larger magnitude so any NaN/inf lands in X
    always_comb begin
        a_f      = bus.in_a;
        b_f      = bus.in_b;
        b_f.sign = b_f.sign ^ bus.in_op;
        swap     = b_f[14:0] > a_f[14:0];
        x_f      = swap ? b_f : a_f;
        y_f      = swap ? a_f : b_f;
        x_nan    = (x_f.exp == EXP_MAX) && (x_f.frac != '0);
        x_inf    = (x_f.exp == EXP_MAX) && (x_f.frac == '0);
        y_inf    = (y_f.exp == EXP_MAX) && (y_f.frac == '0);
        d        = x_f.exp - y_f.exp;
    end

    always_comb begin
        state_d    = state_q;
        first_d    = 1'b0;
        mx_d       = mx_q;
        my_d       = my_q;
        e_d        = e_q;
        sh_d       = sh_q;
        carry_d    = carry_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        spec_inv_d = spec_inv_q;
        spec_inf_d = spec_inf_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        inv_d      = inv_q;
        valid_d    = 1'b0;

        // first NORM cycle applies the adder carry, later cycles shift left
        norm_m = mx_q;
        norm_e = e_q;
        if (first_q) begin
            if (carry_q) begin
                norm_m = {1'b1, mx_q[MANT_W-1:2], mx_q[1] | mx_q[0]};
                norm_e = e_q + 5'd1;
            end
        end else begin
            norm_m = {mx_q[MANT_W-2:0], 1'b0};
            norm_e = e_q - 5'd1;
        end
`ifdef FP16_ROUND_NEAREST_EN
        rnd_up  = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
        rnd_sum = {1'b0, mx_q[MANT_W-1:3]} + {{(FRAC_W+1){1'b0}}, rnd_up};
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d    = ST_ALIGN;
                    first_d    = 1'b1;
                    mx_d       = (x_f.exp != '0) ? {1'b1, x_f.frac, 3'b000} : '0;
                    my_d       = (y_f.exp != '0) ? {1'b1, y_f.frac, 3'b000} : '0;
                    e_d        = x_f.exp;
                    sh_d       = (d > {1'b0, ALIGN_CAP}) ? ALIGN_CAP : d[3:0];
                    sx_d       = x_f.sign;
                    sy_d       = y_f.sign;
                    carry_d    = 1'b0;
                    spec_inv_d = x_nan | (x_inf & y_inf & (x_f.sign != y_f.sign));
                    spec_inf_d = x_inf;
                    ovf_d      = 1'b0;
                    inv_d      = 1'b0;
                end
            end
            ST_ALIGN: begin
                if (first_q) begin
                    if (spec_inv_q) begin
                        res_d   = QNAN;
                        inv_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (spec_inf_q) begin
                        res_d   = {sx_q, INF_P[14:0]};
                        state_d = ST_DONE;
                    end
                end else begin
                    // sticky collects everything shifted past S
                    if (sh_q != 4'd0) begin
                        my_d = {1'b0, my_q[MANT_W-1:2], my_q[1] | my_q[0]};
                        sh_d = sh_q - 4'd1;
                    end
                    if (sh_q <= 4'd1) begin
                        state_d = ST_ADD;
                    end
                end
            end
            ST_ADD: begin
                if (mag == '0 && !add_carry) begin
                    res_d   = {sx_q & sy_q, 15'h0000};
                    state_d = ST_DONE;
                end else begin
                    mx_d    = mag;
                    carry_d = add_carry;
                    sx_d    = add_sign;
                    first_d = 1'b1;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                mx_d    = norm_m;
                e_d     = norm_e;
                carry_d = 1'b0;
                if (norm_e == EXP_MAX) begin
                    res_d   = {sx_q, INF_P[14:0]};
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (norm_m[MANT_W-1]) begin
`ifdef FP16_ROUND_NEAREST_EN
                    state_d = ST_ROUND;
`else
                    res_d   = {sx_q, norm_e, norm_m[MANT_W-2:3]};
                    state_d = ST_DONE;
`endif
                end else if (norm_e <= 5'd1) begin
                    res_d   = {sx_q, 15'h0000};
                    state_d = ST_DONE;
                end
            end
`ifdef FP16_ROUND_NEAREST_EN
            ST_ROUND: begin
                mx_d = {rnd_sum[FRAC_W:0], 3'b000};
                if (rnd_sum[FRAC_W+1]) begin
                    // 1.11..1 rounded up: one more right shift in NORM
                    carry_d = 1'b1;
                    first_d = 1'b1;
                    state_d = ST_NORM;
                end else begin
                    res_d   = {sx_q, e_q, rnd_sum[FRAC_W-1:0]};
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                // results settle in the first DONE cycle; valid follows one cycle later
                if (valid_q && bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            first_q    <= 1'b0;
            mx_q       <= '0;
            my_q       <= '0;
            e_q        <= '0;
            sh_q       <= '0;
            carry_q    <= 1'b0;
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
            spec_inv_q <= 1'b0;
            spec_inf_q <= 1'b0;
            res_q      <= 16'h0000;
            ovf_q      <= 1'b0;
            inv_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            mx_q       <= mx_d;
            my_q       <= my_d;
            e_q        <= e_d;
            sh_q       <= sh_d;
            carry_q    <= carry_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            spec_inv_q <= spec_inv_d;
            spec_inf_q <= spec_inf_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            inv_q      <= inv_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_fp16_addsub_ctrl.sv
// tb/tb_fp16_addsub_ctrl.sv - scoreboard bench for the fp16 add/sub sequencer
module tb_fp16_addsub_ctrl;

`ifdef FP16_ROUND_NEAREST_EN
    localparam int          R        = 1;
    localparam logic [15:0] RES_TIE  = 16'h3C02;
`else
    localparam int          R        = 0;
    localparam logic [15:0] RES_TIE  = 16'h3C01;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp16_addsub_ctrl_if bus ();

    fp16_addsub_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        inv;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // lat < 0 skips the latency comparison; hold = cycles out_ready stays low
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic op,
                           input logic [15:0] res, input logic ovf, input logic inv,
                           input int lat, input int hold);
        exp_t e;
        exp_t got;
        int   cyc;
        e.res = res;
        e.ovf = ovf;
        e.inv = inv;
        e.lat = lat;
        sb.push_back(e);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("in_ready_busy", bus.in_ready, 0);
        cyc = 0;
        while (!bus.out_valid && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("out_valid_seen", bus.out_valid, 1);
        got = sb.pop_front();
        if (got.lat >= 0) check("latency", cyc, got.lat);
        check("out_res", bus.out_res, got.res);
        check("out_ovf", bus.out_ovf, got.ovf);
        check("out_inv", bus.out_inv, got.inv);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", bus.out_valid, 1);
            check("hold_res", bus.out_res, got.res);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_valid", bus.out_valid, 0);
        check("post_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'h0000;
        bus.in_b      = 16'h0000;
        bus.in_op     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_res", bus.out_res, 16'h0000);
        check("rst_out_ovf", bus.out_ovf, 0);
        check("rst_out_inv", bus.out_inv, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 5 + R, 0);
        run_txn(16'h4200, 16'h4200, 1'b1, 16'h0000, 1'b0, 1'b0, 4, 0);
        run_txn(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0, -1, 0);
        run_txn(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b0, 1'b1, 2, 0);
        run_txn(16'h3C01, 16'h1000, 1'b0, RES_TIE, 1'b0, 1'b0, 15 + R, 0);
        run_txn(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b0, 1'b0, 15 + R, 0);
        run_txn(16'h3C00, 16'h3800, 1'b1, 16'h3800, 1'b0, 1'b0, 6 + R, 0);
        run_txn(16'h3800, 16'h3C00, 1'b1, 16'hB800, 1'b0, 1'b0, 6 + R, 0);
        run_txn(16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 4, 0);
        run_txn(16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b1, 2, 0);
        run_txn(16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 1'b0, 1'b0, 2, 0);
        run_txn(16'h4C00, 16'h0400, 1'b0, 16'h4C00, 1'b0, 1'b0, 18 + R, 0);

        // abort a transaction in its second ALIGN cycle
        bus.in_a     = 16'h3C00;
        bus.in_b     = 16'h1400;
        bus.in_op    = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_in_ready", bus.in_ready, 0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_async_valid", bus.out_valid, 0);
        check("rst_async_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_valid", bus.out_valid, 0);
        check("rel_ready", bus.in_ready, 1);
        run_txn(16'h3C00, 16'h1400, 1'b0, 16'h3C01, 1'b0, 1'b0, 14 + R, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
